// File: rtl/add_tree_pkg.sv
// Shared helpers for the pipelined adder tree: depth, per-level widths and term counts.
package add_tree_pkg;

   localparam int ACC_EXT_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 32'sd0;
      for (int p = 32'sd1; p < v; p = p * 32'sd2) begin
         r = r + 32'sd1;
      end
      return r;
   endfunction

   function automatic int lvl_w(input int in_w, input int s);
      return in_w + s + 32'sd1;
   endfunction

   function automatic int terms_at(input int n, input int s);
      return (n + (32'sd1 << s) - 32'sd1) >> s;
   endfunction

endpackage

// File: rtl/add_tree_stage.sv
// One adder-tree level: pairwise extend-and-add of TERMS_IN lanes into a valid/ready register.
module add_tree_stage
   import add_tree_pkg::*;
#(
   parameter  int TERMS_IN  = 4,
   parameter  int W_IN      = 6,
   parameter  int SIGNED    = 0,
   localparam int TERMS_OUT = terms_at(TERMS_IN, 32'sd1),
   localparam int W_OUT     = W_IN + 32'sd1
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       valid_up,
   output logic                       ready_up,
   input  logic [TERMS_IN*W_IN-1:0]   data_up,
   output logic                       valid_dn,
   input  logic                       ready_dn,
   output logic [TERMS_OUT*W_OUT-1:0] data_dn
);

   logic                       load_s;
   logic [TERMS_OUT*W_OUT-1:0] sum_s;
   logic                       valid_r;
   logic [TERMS_OUT*W_OUT-1:0] data_r;

   genvar j;
   for (j = 0; j < TERMS_OUT; j++) begin : g_pair
      logic [W_IN-1:0]  a_s;
      logic [W_IN-1:0]  b_s;
      logic [W_OUT-1:0] a_ext_s;
      logic [W_OUT-1:0] b_ext_s;

      assign a_s = data_up[(32'sd2*j)*W_IN +: W_IN];
      // An unpaired last term is added to zero, i.e. passed through extended
      if ((32'sd2*j + 32'sd1) < TERMS_IN) begin : g_b
         assign b_s = data_up[(32'sd2*j + 32'sd1)*W_IN +: W_IN];
      end else begin : g_odd
         assign b_s = '0;
      end

      if (SIGNED != 0) begin : g_sx
         assign a_ext_s = {a_s[W_IN-1], a_s};
         assign b_ext_s = {b_s[W_IN-1], b_s};
      end else begin : g_zx
         assign a_ext_s = {1'b0, a_s};
         assign b_ext_s = {1'b0, b_s};
      end

      assign sum_s[j*W_OUT +: W_OUT] = a_ext_s + b_ext_s;
   end

   // An empty register always refills, which is what collapses bubbles
   assign load_s   = ~valid_r | ready_dn;
   assign ready_up = load_s;

   // Level register: holds while full and downstream is stalled
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_r <= 1'b0;
         data_r  <= '0;
      end else if (load_s) begin
         valid_r <= valid_up;
         if (valid_up) begin
            data_r <= sum_s;
         end
      end
   end

   assign valid_dn = valid_r;
   assign data_dn  = data_r;

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined NUM_IN-lane adder tree, one register per level, valid/ready on both sides.
// Optional running accumulator of delivered sums when ADD_TREE_ACC_EN is defined.
module add_tree_pipe
   import add_tree_pkg::*;
#(
   parameter  int NUM_IN = 4,
   parameter  int IN_W   = 6,
   parameter  int SIGNED = 0,
   localparam int LVL    = clog2(NUM_IN),
   localparam int OUT_W  = IN_W + LVL
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [NUM_IN*IN_W-1:0] in_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [OUT_W-1:0]       out_sum_o
`ifdef ADD_TREE_ACC_EN
   ,
   input  logic                   acc_clr_i,
   output logic [OUT_W+ACC_EXT_W-1:0] out_acc_o
`endif
);

   localparam int PAD_N = 32'sd1 << LVL;

   logic [PAD_N*IN_W-1:0] lanes_s;

   // Zero lanes round the operand count up to a power of two
   always_comb begin
      lanes_s                      = '0;
      lanes_s[NUM_IN*IN_W-1:0]     = in_data_i;
   end

   genvar s;
   for (s = 0; s < LVL; s++) begin : g_lvl
      localparam int T_IN  = terms_at(PAD_N, s);
      localparam int T_OUT = terms_at(PAD_N, s + 32'sd1);
      localparam int W_IN  = IN_W + s;
      localparam int W_OUT = lvl_w(IN_W, s);

      logic                   v_in_s;
      logic                   r_in_s;
      logic [T_IN*W_IN-1:0]   d_in_s;
      logic                   v_out_s;
      logic                   r_out_s;
      logic [T_OUT*W_OUT-1:0] d_out_s;

      if (s == 0) begin : g_head
         assign v_in_s = in_valid_i;
         assign d_in_s = lanes_s;
      end else begin : g_link
         assign v_in_s = g_lvl[s-1].v_out_s;
         assign d_in_s = g_lvl[s-1].d_out_s;
      end

      if (s == LVL - 1) begin : g_tail
         assign r_out_s = out_ready_i;
      end else begin : g_mid
         assign r_out_s = g_lvl[s+1].r_in_s;
      end

      add_tree_stage #(
         .TERMS_IN (T_IN),
         .W_IN     (W_IN),
         .SIGNED   (SIGNED)
      ) u_stage (
         .clk_i    (clk_i),
         .rst_n_i  (rst_n_i),
         .valid_up (v_in_s),
         .ready_up (r_in_s),
         .data_up  (d_in_s),
         .valid_dn (v_out_s),
         .ready_dn (r_out_s),
         .data_dn  (d_out_s)
      );
   end

   assign in_ready_o  = g_lvl[0].r_in_s;
   assign out_valid_o = g_lvl[LVL-1].v_out_s;
   assign out_sum_o   = g_lvl[LVL-1].d_out_s;

`ifdef ADD_TREE_ACC_EN
   localparam int ACC_W = OUT_W + ACC_EXT_W;

   logic             out_fire_s;
   logic [ACC_W-1:0] sum_ext_s;
   logic [ACC_W-1:0] acc_r;

   assign out_fire_s = out_valid_o & out_ready_i;

   if (SIGNED != 0) begin : g_acc_sx
      assign sum_ext_s = {{ACC_EXT_W{out_sum_o[OUT_W-1]}}, out_sum_o};
   end else begin : g_acc_zx
      assign sum_ext_s = {{ACC_EXT_W{1'b0}}, out_sum_o};
   end

   // Running total; a clear coinciding with a delivery keeps only that sum
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_r <= '0;
      end else if (acc_clr_i) begin
         acc_r <= out_fire_s ? sum_ext_s : '0;
      end else if (out_fire_s) begin
         acc_r <= acc_r + sum_ext_s;
      end
   end

   assign out_acc_o = acc_r;
`endif

endmodule

// File: tb/tb_add_tree_pipe.sv
// Directed and scoreboard checks of add_tree_pipe: default, signed and 5-lane builds.
// Covers the ADD_TREE_ACC_EN accumulator when that macro is defined.
module tb_add_tree_pipe;

   localparam int NV = 10000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready;
   logic [23:0] in_data;
   logic        d_in_ready, d_out_valid;
   logic [7:0]  d_out_sum;
   logic        s_in_ready, s_out_valid;
   logic [7:0]  s_out_sum;
   logic        n5_valid, n5_oready, n5_in_ready, n5_out_valid;
   logic [39:0] n5_data;
   logic [10:0] n5_sum;
`ifdef ADD_TREE_ACC_EN
   logic        acc_clr;
   logic [23:0] d_acc, s_acc;
   logic [26:0] n5_acc;
`endif

   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_sent, n_got;
   logic [7:0]  exp_q[$];
   logic        hold_pend, last_fire;
   logic [7:0]  hold_sum;

   typedef struct {
      logic [23:0] data;
      logic [7:0]  exp_u;
      logic [7:0]  exp_s;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   add_tree_pipe u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(d_in_ready),
      .in_data_i(in_data), .out_valid_o(d_out_valid), .out_ready_i(out_ready),
      .out_sum_o(d_out_sum)
`ifdef ADD_TREE_ACC_EN
      , .acc_clr_i(acc_clr), .out_acc_o(d_acc)
`endif
   );

   add_tree_pipe #(.SIGNED(1)) u_sgn (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
      .in_data_i(in_data), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
      .out_sum_o(s_out_sum)
`ifdef ADD_TREE_ACC_EN
      , .acc_clr_i(acc_clr), .out_acc_o(s_acc)
`endif
   );

   add_tree_pipe #(.NUM_IN(5), .IN_W(8)) u_n5 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(n5_valid), .in_ready_o(n5_in_ready),
      .in_data_i(n5_data), .out_valid_o(n5_out_valid), .out_ready_i(n5_oready),
      .out_sum_o(n5_sum)
`ifdef ADD_TREE_ACC_EN
      , .acc_clr_i(acc_clr), .out_acc_o(n5_acc)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] lanes4(input logic [5:0] l3, input logic [5:0] l2,
                                          input logic [5:0] l1, input logic [5:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [23:0] lanes_all(input logic [5:0] v);
      return {v, v, v, v};
   endfunction

   function automatic logic [7:0] sum_u(input logic [23:0] d);
      logic [7:0] t;
      t = 8'd0;
      for (int k = 0; k < 4; k++) t = t + {2'b00, d[k*6 +: 6]};
      return t;
   endfunction

   // One scoreboard cycle on u_dut: sample at negedge, then step to next drive point
   task automatic sb_step();
      logic in_fire, out_fire;
      @(negedge clk);
      in_fire  = in_valid & d_in_ready;
      out_fire = d_out_valid & out_ready;
      if (hold_pend) begin
         check("hold_valid", d_out_valid, 1'b1);
         check("hold_sum", d_out_sum, hold_sum);
      end
      hold_pend = d_out_valid & ~out_ready;
      hold_sum  = d_out_sum;
      if (out_fire) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_extra: got 0x%0h, want no output", d_out_sum);
         end else begin
            check("sb_sum", d_out_sum, exp_q.pop_front());
         end
         n_got++;
      end
      if (in_fire) begin
         exp_q.push_back(sum_u(in_data));
         n_sent++;
      end
      @(posedge clk);
      #1;
      last_fire = in_fire;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      n5_valid = 1'b0; n5_oready = 1'b1; n5_data = '0;
      hold_pend = 1'b0; last_fire = 1'b0; hold_sum = '0;
`ifdef ADD_TREE_ACC_EN
      acc_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", d_out_valid, 1'b0);
      check("rst_sum", d_out_sum, 8'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", d_in_ready, 1'b1);
      check("rst_valid_rel", d_out_valid, 1'b0);

      // Table: unsigned and signed expectations for the same lane pattern
      for (int i = 1; i <= 30; i++)
         tbl.push_back('{lanes_all(6'(i)), 8'(4 * i), 8'(4 * i)});
      tbl.push_back('{lanes_all(6'h3f), 8'd252, 8'hfc});
      tbl.push_back('{lanes_all(6'h20), 8'h80, 8'h80});
      tbl.push_back('{lanes4(6'd4, 6'd3, 6'd2, 6'd1), 8'd10, 8'd10});
      tbl.push_back('{lanes4(6'h00, 6'h3f, 6'h00, 6'h3f), 8'd126, 8'hfe});
      tbl.push_back('{lanes4(6'h3e, 6'h01, 6'h20, 6'h1f), 8'h7e, 8'hfe});
      tbl.push_back('{lanes_all(6'h00), 8'd0, 8'd0});

      for (int c = 0; c < tbl.size() + 3; c++) begin
         if (c < tbl.size()) begin
            in_valid = 1'b1;
            in_data  = tbl[c].data;
         end else begin
            in_valid = 1'b0;
            in_data  = '0;
         end
         @(negedge clk);
         check("tbl_in_ready", d_in_ready, 1'b1);
         if (c >= 2 && c < tbl.size() + 2) begin
            check("tbl_valid", d_out_valid, 1'b1);
            check("tbl_sum_u", d_out_sum, tbl[c-2].exp_u);
            check("tbl_sum_s", s_out_sum, tbl[c-2].exp_s);
         end else begin
            check("tbl_idle", d_out_valid, 1'b0);
         end
         @(posedge clk);
         #1;
      end

      // Five lanes of 8 bits: zero-padded tree, three levels deep
      for (int c = 0; c < 6; c++) begin
         n5_valid = (c < 2);
         n5_data  = (c == 0) ? {5{8'hff}} : {8'd200, 8'd40, 8'd30, 8'd20, 8'd10};
         @(negedge clk);
         if (c == 0) check("n5_in_ready", n5_in_ready, 1'b1);
         if (c == 3) begin
            check("n5_valid0", n5_out_valid, 1'b1);
            check("n5_sum0", n5_sum, 11'd1275);
         end else if (c == 4) begin
            check("n5_valid1", n5_out_valid, 1'b1);
            check("n5_sum1", n5_sum, 11'd300);
         end else begin
            check("n5_idle", n5_out_valid, 1'b0);
         end
         @(posedge clk);
         #1;
      end

      // Reset with two undelivered vectors in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = lanes_all(6'd1);
      tick();
      in_data = lanes_all(6'd2);
      tick();
      in_valid = 1'b0;
      check("pre_rst_valid", d_out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", d_out_valid, 1'b0);
      check("rst_async_sum", d_out_sum, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("rst_no_stale", d_out_valid, 1'b0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = lanes_all(6'd7);
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("post_rst_valid", d_out_valid, 1'b1);
      check("post_rst_sum", d_out_sum, 8'd28);
      tick();

      // Backpressure: one vector per stage fills, then input stalls
      exp_q.delete();
      n_sent = 0; n_got = 0; hold_pend = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = lanes_all(6'd1);
      repeat (10) begin
         sb_step();
         if (last_fire) in_data = lanes_all(6'(n_sent + 1));
      end
      check("bp_accepts", n_sent, 2);
      check("bp_in_ready", d_in_ready, 1'b0);
      check("bp_out_valid", d_out_valid, 1'b1);
      check("bp_out_sum", d_out_sum, 8'd4);
      out_ready = 1'b1;
      for (int c = 0; c < 40 && n_got < 8; c++) begin
         sb_step();
         if (last_fire) begin
            if (n_sent < 8) in_data = lanes_all(6'(n_sent + 1));
            else in_valid = 1'b0;
         end
      end
      check("bp_delivered", n_got, 8);
      check("bp_left", exp_q.size(), 0);

      // Random valid/ready against the scoreboard
      exp_q.delete();
      n_sent = 0; n_got = 0; hold_pend = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 60000 && n_got < NV; c++) begin
         if (!in_valid && n_sent < NV && $urandom_range(3) != 0) begin
            in_valid = 1'b1;
            in_data  = 24'($urandom);
         end
         out_ready = ($urandom_range(3) != 0);
         sb_step();
         if (last_fire) in_valid = 1'b0;
      end
      check("rnd_delivered", n_got, NV);
      check("rnd_left", exp_q.size(), 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

`ifdef ADD_TREE_ACC_EN
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      check("acc_clr", d_acc, 24'd0);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = (k == 0) ? lanes4(6'd4, 6'd3, 6'd2, 6'd1) :
                    (k == 1) ? lanes_all(6'd5) : lanes4(6'd10, 6'd10, 6'd5, 6'd5);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      check("acc_60", d_acc, 24'd60);
      in_valid = 1'b1;
      in_data  = lanes4(6'd0, 6'd0, 6'd0, 6'd5);
      tick();
      in_valid = 1'b0;
      tick();
      check("acc_clr_valid", d_out_valid, 1'b1);
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      check("acc_clr_add", d_acc, 24'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
